// File: rtl/scalar_rf_writeback.sv
// scalar_rf_writeback
// Write-side front end for the scalar register file. The ALU result path and
// the load-return FIFO share the RF write port. Load returns are preferred
// because they are older. An ALU that has lost STARVE_LIMIT times in a row
// is force-granted. A pending scoreboard tracks destinations with writes
// still outstanding, and writes to the top (vector-config) register are
// flagged.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   alu_valid_i/alu_ready_o         ALU request handshake (ready = ALU wins)
//   alu_rd_i/alu_data_i/alu_func_i  ALU write payload
//   ld_valid_i/ld_ready_o           load-return handshake (ready = FIFO not full)
//   ld_rd_i/ld_data_i               load write payload
//   issue_valid_i/issue_rd_i        issued instruction destination (sets pending)
//   rd_o/wen_o/rd_data_o/func_o     registered RF write port
//   vcfg_wr_o                       write to register 2**REG_WIDTH-1, with wen_o
//   pending_o                       per-register outstanding-write bits
module scalar_rf_writeback #(
  parameter int DATA_WIDTH    = 16,
  parameter int REG_WIDTH     = 4,
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid_i,
  output logic                    alu_ready_o,
  input  logic [REG_WIDTH-1:0]    alu_rd_i,
  input  logic [DATA_WIDTH-1:0]   alu_data_i,
  input  logic [1:0]              alu_func_i,
  input  logic                    ld_valid_i,
  output logic                    ld_ready_o,
  input  logic [REG_WIDTH-1:0]    ld_rd_i,
  input  logic [DATA_WIDTH-1:0]   ld_data_i,
  input  logic                    issue_valid_i,
  input  logic [REG_WIDTH-1:0]    issue_rd_i,
  output logic [REG_WIDTH-1:0]    rd_o,
  output logic                    wen_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [1:0]              func_o,
  output logic                    vcfg_wr_o,
  output logic [2**REG_WIDTH-1:0] pending_o
);
  localparam int NREG = 2**REG_WIDTH;
  localparam int PW   = $clog2(LD_FIFO_DEPTH);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]           FULL_CNT = (PW+1)'(LD_FIFO_DEPTH);
  localparam logic [SW-1:0]         SLIM     = SW'(STARVE_LIMIT);
  localparam logic [REG_WIDTH-1:0]  VCFG_RD  = '1;
  localparam logic [NREG-1:0]       ONE      = NREG'(1);

  // load-return FIFO; storage needs no reset, the count defines validity
  logic [REG_WIDTH-1:0]  r_mem_rd   [LD_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [LD_FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_cnt;
  logic [SW-1:0]         r_starve;
  logic [NREG-1:0]       r_pend;

  logic                  w_full, w_empty, w_enq, w_alu_win, w_ld_win, w_gnt;
  logic [REG_WIDTH-1:0]  w_gnt_rd;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [1:0]            w_gnt_func;
  logic [NREG-1:0]       w_set, w_clr;

  assign w_full      = (r_cnt == FULL_CNT);
  assign w_empty     = (r_cnt == '0);
  assign ld_ready_o  = !w_full;
  assign w_enq       = ld_valid_i && !w_full;
  // FIFO head wins unless the ALU has been starved long enough
  assign w_alu_win   = alu_valid_i && (w_empty || r_starve == SLIM);
  assign w_ld_win    = !w_empty && !w_alu_win;
  assign w_gnt       = w_alu_win || w_ld_win;
  assign alu_ready_o = w_alu_win;

  assign w_gnt_rd   = w_alu_win ? alu_rd_i   : r_mem_rd[r_rptr];
  assign w_gnt_data = w_alu_win ? alu_data_i : r_mem_data[r_rptr];
  assign w_gnt_func = w_alu_win ? alu_func_i : 2'b00;

  // set is applied after clear so a newly issued producer stays pending
  assign w_clr = w_gnt ? (ONE << w_gnt_rd) : '0;
  assign w_set = (issue_valid_i && issue_rd_i != '0) ? (ONE << issue_rd_i) : '0;
  assign pending_o = r_pend;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_rd[r_wptr]   <= ld_rd_i;
      r_mem_data[r_wptr] <= ld_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_pend   <= '0;
    end else begin
      if (w_enq)    r_wptr <= r_wptr + 1'b1;
      if (w_ld_win) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_ld_win})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (alu_valid_i && !w_alu_win)
        r_starve <= (r_starve == SLIM) ? SLIM : r_starve + 1'b1;
      else
        r_starve <= '0;
      r_pend <= ((r_pend & ~w_clr) | w_set) & ~ONE;
    end
  end

  // registered RF write port; payload holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_o      <= '0;
      wen_o     <= 1'b0;
      rd_data_o <= '0;
      func_o    <= 2'b00;
      vcfg_wr_o <= 1'b0;
    end else begin
      wen_o     <= w_gnt && (w_gnt_rd != '0);
      vcfg_wr_o <= w_gnt && (w_gnt_rd == VCFG_RD);
      if (w_gnt) begin
        rd_o      <= w_gnt_rd;
        rd_data_o <= w_gnt_data;
        func_o    <= w_gnt_func;
      end
    end
  end
endmodule

// File: tb/tb_scalar_rf_writeback.sv
// Bench for scalar_rf_writeback: directed steps followed by random traffic,
// checked against a queue-based model of the FIFO, arbiter and scoreboard.
module tb_scalar_rf_writeback;
  localparam int DW = 16, RW = 4, DEPTH = 4, SL = 3;

  logic          clk = 1'b0, rst_n;
  logic          alu_valid_i, alu_ready_o, ld_valid_i, ld_ready_o, issue_valid_i;
  logic [RW-1:0] alu_rd_i, ld_rd_i, issue_rd_i, rd_o;
  logic [DW-1:0] alu_data_i, ld_data_i, rd_data_o;
  logic [1:0]    alu_func_i, func_o;
  logic          wen_o, vcfg_wr_o;
  logic [15:0]   pending_o;

  always #5 clk = ~clk;

  scalar_rf_writeback #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .LD_FIFO_DEPTH(DEPTH),
                        .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i),
    .alu_data_i(alu_data_i), .alu_func_i(alu_func_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i),
    .ld_data_i(ld_data_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rd_o(rd_o), .wen_o(wen_o), .rd_data_o(rd_data_o), .func_o(func_o),
    .vcfg_wr_o(vcfg_wr_o), .pending_o(pending_o));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // reference model state
  int          m_rd_q[$], m_data_q[$];
  int          m_starve;
  logic [15:0] m_pend;
  int          h_rd, h_data, h_func;
  bit          h_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit av, input int ard, input int adata, input int afunc,
                       input bit lv, input int lrd, input int ldata,
                       input bit iv, input int ird);
    alu_valid_i = av;  alu_rd_i = ard[RW-1:0]; alu_data_i = adata[DW-1:0];
    alu_func_i = afunc[1:0];
    ld_valid_i = lv;   ld_rd_i = lrd[RW-1:0];  ld_data_i = ldata[DW-1:0];
    issue_valid_i = iv; issue_rd_i = ird[RW-1:0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // called just after a negedge with inputs driven; returns at the next negedge
  task automatic cycle();
    bit empty, full, awin, lwin, gnt, av, lv, iv, exp_wen;
    int grd, gdata, gfunc, lrd, ldata, ird;
    #1;
    empty = (m_rd_q.size() == 0);
    full  = (m_rd_q.size() == DEPTH);
    av = alu_valid_i; lv = ld_valid_i; iv = issue_valid_i;
    lrd = int'(ld_rd_i); ldata = int'(ld_data_i); ird = int'(issue_rd_i);
    awin = av && (empty || m_starve == SL);
    lwin = !empty && !awin;
    gnt  = awin || lwin;
    chk("alu_ready", 32'(alu_ready_o), 32'(awin));
    chk("ld_ready", 32'(ld_ready_o), 32'(!full));
    grd = 0; gdata = 0; gfunc = 0;
    if (awin) begin
      grd = int'(alu_rd_i); gdata = int'(alu_data_i); gfunc = int'(alu_func_i);
    end else if (lwin) begin
      grd = m_rd_q.pop_front(); gdata = m_data_q.pop_front(); gfunc = 0;
    end
    @(posedge clk);
    if (lv && !full) begin m_rd_q.push_back(lrd); m_data_q.push_back(ldata); end
    if (av && !awin) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
    else             m_starve = 0;
    if (gnt) m_pend[grd] = 1'b0;
    if (iv && ird != 0) m_pend[ird] = 1'b1;
    exp_wen = gnt && grd != 0;
    if (gnt) begin
      // a discarded rd==0 write leaves the held payload unspecified
      h_valid = (grd != 0); h_rd = grd; h_data = gdata; h_func = gfunc;
    end
    #1;
    chk("wen", 32'(wen_o), 32'(exp_wen));
    chk("vcfg_wr", 32'(vcfg_wr_o), 32'(exp_wen && grd == 15));
    chk("pending", 32'(pending_o), 32'(m_pend));
    if (h_valid) begin
      chk("rd", 32'(rd_o), h_rd);
      chk("rd_data", 32'(rd_data_o), h_data);
      chk("func", 32'(func_o), h_func);
    end
    @(negedge clk);
  endtask

  // asserted between edges; outputs must clear without a clock
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_rd_q.delete(); m_data_q.delete();
    m_starve = 0; m_pend = '0;
    h_valid = 1; h_rd = 0; h_data = 0; h_func = 0;
    chk("rst_wen", 32'(wen_o), 0);
    chk("rst_vcfg", 32'(vcfg_wr_o), 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_ld_ready", 32'(ld_ready_o), 1);
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_data", 32'(rd_data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int f;
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // ALU write to rd=3 with pending[3] set beforehand
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3);        cycle();
    drive(1, 3, 'h1234, 0, 0, 0, 0, 0, 0);   cycle();
    idle(); cycle();

    // back-to-back loads rd=1..4
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 1, i, 'hA000 + i, 0, 0); cycle();
    end
    idle(); repeat (3) cycle();

    // ALU held valid with continuous loads: FIFO fills, ALU wins every 4th
    for (int i = 0; i < 20; i++) begin
      drive(1, 5, 'h5500 + i, 0, 1, 1 + (i % 14), 'hB000 + i, 0, 0); cycle();
    end
    idle(); repeat (6) cycle();

    // rd=0 writes are consumed silently
    drive(1, 0, 'h1111, 0, 0, 0, 0, 0, 0);   cycle();
    drive(0, 0, 0, 0, 1, 0, 'h2222, 0, 0);   cycle();
    idle(); repeat (2) cycle();

    // vector-config register writes
    drive(1, 15, 'h0F08, 0, 0, 0, 0, 0, 0);  cycle();
    drive(1, 15, 'h7700, 3, 0, 0, 0, 0, 0);  cycle();
    drive(0, 0, 0, 0, 1, 15, 'hCAFE, 0, 0);  cycle();
    idle(); repeat (2) cycle();

    // set beats clear on the same register
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7);        cycle();
    drive(1, 7, 'h0707, 2, 0, 0, 0, 1, 7);   cycle();
    drive(1, 7, 'h0770, 0, 0, 0, 0, 0, 0);   cycle();
    idle(); cycle();

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      drive(1, 9, 'h9000 + i, 0, 1, 10 + i, 'hD000 + i, 1, 4 + i); cycle();
    end
    do_reset();
    idle(); repeat (3) cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      f = $urandom_range(0, 2);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 65535),
            (f == 0) ? 0 : f + 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 65535),
            $urandom_range(0, 1), $urandom_range(0, 15));
      cycle();
      if (i == 200) do_reset();
    end
    idle(); repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
